frame_decoder: RTL and testbench

FRAME_DECODER -- requirements
Module: frame_decoder

---
 rtl/uart_frame_pkg.sv | 33 +++
 rtl/gap_timer.sv | 39 +++
 rtl/frame_decoder.sv | 168 ++++++++++++++++
 tb/tb_frame_decoder.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame link, used by both the decoder and the sender.
//   state_e          : decoder FSM states
//   Err*             : err_code values reported by the decoder
//   Default*         : default terminator byte and PWM clamp/reset constants
//   clamp_width()    : unsigned 24-bit clamp used to turn a payload into a PWM width
package uart_frame_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StCollect  = 2'd1,
    StWaitTerm = 2'd2,
    StDiscard  = 2'd3
  } state_e;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrBadTerm = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;
  localparam logic [1:0] ErrBreak   = 2'b11;

  localparam logic [7:0]  DefaultTerminator = 8'h0A;
  localparam logic [23:0] DefaultPwmMin     = 24'd27_000;
  localparam logic [23:0] DefaultPwmMax     = 24'd67_500;
  localparam logic [23:0] DefaultPwmDefault = 24'd54_054;

  function automatic logic [23:0] clamp_width(input logic [23:0] value,
                                              input logic [23:0] lo,
                                              input logic [23:0] hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/gap_timer.sv
// Inter-byte gap timer.
//   clk, resetn : clock and asynchronous active-low reset
//   clr         : clear the count (takes priority over en)
//   en          : count one per cycle while set
//   expired     : count has reached CYCLES; the count saturates there
module gap_timer #(
  parameter int unsigned CYCLES = 2_700_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(CYCLES + 1);

  logic [W-1:0] count_q, count_d;

  assign expired = (count_q == W'(CYCLES));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expired) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/frame_decoder.sv
// Decodes byte frames (PAYLOAD_BYTES payload bytes, MSB first, then TERMINATOR) from a UART
// receiver into a raw payload, a clamped PWM width and an accepted-frame counter.
//   clk, resetn           : clock and asynchronous active-low reset
//   rx_valid/rx_data      : received byte strobe and data
//   rx_break              : line break from the receiver
//   frame_data            : payload of the last accepted frame
//   frame_valid           : one-cycle pulse on acceptance
//   frame_error           : one-cycle pulse on rejection
//   err_code              : cause of the last rejection, held
//   pwm_width             : clamped payload, held between frames
//   frame_count           : accepted frames, wrapping
module frame_decoder
  import uart_frame_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES  = 3,
  parameter logic [7:0]  TERMINATOR     = DefaultTerminator,
  parameter int unsigned TIMEOUT_CYCLES = 2_700_000,
  parameter logic [23:0] PWM_MIN        = DefaultPwmMin,
  parameter logic [23:0] PWM_MAX        = DefaultPwmMax,
  parameter logic [23:0] PWM_DEFAULT    = DefaultPwmDefault
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_break,
  output logic [23:0] frame_data,
  output logic        frame_valid,
  output logic        frame_error,
  output logic [1:0]  err_code,
  output logic [23:0] pwm_width,
  output logic [7:0]  frame_count
);

  localparam int unsigned CntW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

  state_e            state_q, state_d;
  logic [23:0]       payload_q, payload_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              accept, reject;
  logic [1:0]        err_sel;
  logic              timer_en, timer_clr, timer_expired;

  logic [23:0] frame_data_q, frame_data_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_error_q, frame_error_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [23:0] pwm_width_q, pwm_width_d;
  logic [7:0]  frame_count_q, frame_count_d;

  // The timer only runs mid-frame; holding it clear elsewhere means a stale count can never
  // leak into the next frame.
  assign timer_en  = (state_q == StCollect) || (state_q == StWaitTerm);
  assign timer_clr = rx_valid || !timer_en;

  gap_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      payload_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next state. Priority: break, then byte, then timeout (a byte on the expiry cycle wins).
  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    reject    = 1'b0;
    err_sel   = ErrNone;
    if (rx_break) begin
      state_d = StDiscard;
      if (timer_en) begin
        reject  = 1'b1;
        err_sel = ErrBreak;
      end
    end else if (rx_valid) begin
      unique case (state_q)
        StIdle: begin
          payload_d = {16'h0000, rx_data};
          cnt_d     = CntW'(1);
          state_d   = (PAYLOAD_BYTES == 1) ? StWaitTerm : StCollect;
        end
        StCollect: begin
          payload_d = {payload_q[15:0], rx_data};
          cnt_d     = cnt_q + CntW'(1);
          if (cnt_q == CntW'(PAYLOAD_BYTES - 1)) state_d = StWaitTerm;
        end
        StWaitTerm: begin
          if (rx_data == TERMINATOR) begin
            accept  = 1'b1;
            state_d = StIdle;
          end else begin
            reject  = 1'b1;
            err_sel = ErrBadTerm;
            state_d = StDiscard;
          end
        end
        StDiscard: begin
          if (rx_data == TERMINATOR) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (timer_en && timer_expired) begin
      reject  = 1'b1;
      err_sel = ErrTimeout;
      state_d = StIdle;
    end
  end

  // Registered outputs, updated one cycle after the deciding input.
  always_comb begin
    frame_data_d  = frame_data_q;
    pwm_width_d   = pwm_width_q;
    frame_count_d = frame_count_q;
    err_code_d    = err_code_q;
    frame_valid_d = accept;
    frame_error_d = reject;
    if (accept) begin
      frame_data_d  = payload_q;
      pwm_width_d   = clamp_width(payload_q, PWM_MIN, PWM_MAX);
      frame_count_d = frame_count_q + 8'd1;
    end
    if (reject) err_code_d = err_sel;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      err_code_q    <= ErrNone;
      pwm_width_q   <= PWM_DEFAULT;
      frame_count_q <= '0;
    end else begin
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      err_code_q    <= err_code_d;
      pwm_width_q   <= pwm_width_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign err_code    = err_code_q;
  assign pwm_width   = pwm_width_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_decoder.sv
module tb_frame_decoder;

  localparam int unsigned T    = 40;
  localparam logic [7:0]  TERM = 8'h0A;
  localparam int unsigned PMIN = 27_000;
  localparam int unsigned PMAX = 67_500;
  localparam int unsigned PDEF = 54_054;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_break = 1'b0;
  logic [23:0] frame_data;
  logic        frame_valid;
  logic        frame_error;
  logic [1:0]  err_code;
  logic [23:0] pwm_width;
  logic [7:0]  frame_count;

  frame_decoder #(
    .PAYLOAD_BYTES  (3),
    .TERMINATOR     (TERM),
    .TIMEOUT_CYCLES (T),
    .PWM_MIN        (24'd27_000),
    .PWM_MAX        (24'd67_500),
    .PWM_DEFAULT    (24'd54_054)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_break    (rx_break),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .err_code    (err_code),
    .pwm_width   (pwm_width),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          is_err;
    int unsigned stamp;
    logic [23:0] data;
    logic [23:0] pwm;
    logic [7:0]  cnt;
    logic [1:0]  code;
  } ev_t;

  ev_t         expq[$];
  logic [7:0]  pbuf[$];      // bytes of the frame being assembled
  bit          discarding;
  int unsigned gap;          // idle cycles since the last byte of the current frame
  logic [23:0] m_data, m_pwm;
  logic [7:0]  m_cnt;
  logic [1:0]  m_code;

  function automatic logic [23:0] ref_clamp(input int unsigned v);
    if (v < PMIN) return 24'(PMIN);
    if (v > PMAX) return 24'(PMAX);
    return 24'(v);
  endfunction

  task automatic model_reset();
    pbuf.delete();
    expq.delete();
    discarding = 0;
    gap        = 0;
    m_data     = '0;
    m_pwm      = 24'(PDEF);
    m_cnt      = '0;
    m_code     = 2'b00;
  endtask

  task automatic push_ev(input bit is_err);
    ev_t e;
    e.is_err = is_err;
    e.stamp  = cyc + 1;
    e.data   = m_data;
    e.pwm    = m_pwm;
    e.cnt    = m_cnt;
    e.code   = m_code;
    expq.push_back(e);
  endtask

  task automatic model_error(input logic [1:0] code);
    m_code = code;
    push_ev(1'b1);
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit brk);
    int unsigned value;
    if (brk) begin
      if (pbuf.size() > 0) model_error(2'b11);
      pbuf.delete();
      discarding = 1;
    end else if (v) begin
      gap = 0;
      if (discarding) begin
        if (d == TERM) discarding = 0;
      end else if (pbuf.size() < 3) begin
        pbuf.push_back(d);
      end else begin
        if (d == TERM) begin
          value  = 65536 * pbuf[0] + 256 * pbuf[1] + pbuf[2];
          m_data = 24'(value);
          m_pwm  = ref_clamp(value);
          m_cnt  = m_cnt + 8'd1;
          push_ev(1'b0);
        end else begin
          model_error(2'b01);
          discarding = 1;
        end
        pbuf.delete();
      end
    end else if (pbuf.size() > 0) begin
      if (gap >= T) begin
        model_error(2'b10);
        pbuf.delete();
      end else begin
        gap++;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step(input bit v, input logic [7:0] d, input bit brk);
    rx_valid = v;
    rx_data  = d;
    rx_break = brk;
    model_step(v, d, brk);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_break = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic send_frame(input logic [23:0] p, input logic [7:0] t, input int unsigned gmax);
    logic [7:0] bytes[4];
    bytes[0] = p[23:16];
    bytes[1] = p[15:8];
    bytes[2] = p[7:0];
    bytes[3] = t;
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, gmax));
      send(bytes[i]);
    end
  endtask

  task automatic check_held(input string tag);
    chk({tag, "/frame_data"},  32'(frame_data),  32'(m_data));
    chk({tag, "/pwm_width"},   32'(pwm_width),   32'(m_pwm));
    chk({tag, "/frame_count"}, 32'(frame_count), 32'(m_cnt));
    chk({tag, "/err_code"},    32'(err_code),    32'(m_code));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "/frame_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, "/frame_error"}, 32'(frame_error), 32'd0);
    chk({tag, "/frame_data"},  32'(frame_data),  32'd0);
    chk({tag, "/err_code"},    32'(err_code),    32'd0);
    chk({tag, "/pwm_width"},   32'(pwm_width),   32'(PDEF));
    chk({tag, "/frame_count"}, 32'(frame_count), 32'd0);
  endtask

  // ---------------- monitor ----------------
  ev_t mon_e;
  always @(negedge clk) begin
    if (resetn) begin
      if (frame_valid && frame_error) begin
        chk("valid_error_exclusive", 32'(frame_valid & frame_error), 32'd0);
      end
      if (frame_valid || frame_error) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: valid=%0b error=%0b, expected no pulse (cycle %0d)",
                   frame_valid, frame_error, cyc);
        end else begin
          mon_e = expq.pop_front();
          chk("pulse_kind_error", 32'(frame_error), 32'(mon_e.is_err));
          chk("pulse_cycle",      32'(cyc),         32'(mon_e.stamp));
          chk("frame_data",       32'(frame_data),  32'(mon_e.data));
          chk("pwm_width",        32'(pwm_width),   32'(mon_e.pwm));
          chk("frame_count",      32'(frame_count), 32'(mon_e.cnt));
          chk("err_code",         32'(err_code),    32'(mon_e.code));
        end
      end else if (expq.size() > 0 && expq[0].stamp <= cyc) begin
        mon_e = expq.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_pulse: expected %s pulse at cycle %0d did not occur",
                 mon_e.is_err ? "error" : "valid", mon_e.stamp);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned kind;
    int unsigned cut;
    logic [23:0] p;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    resetn = 1'b1;

    // Clamp high, in-range, clamp low.
    send_frame(24'h140000, TERM, 0);
    send_frame(24'h00D336, TERM, 0);
    idle(2);
    check_held("in_range");
    send_frame(24'h000010, TERM, 0);
    idle(2);
    check_held("clamp_low");

    // Bad terminator, discard until terminator, then recovery.
    send_frame(24'h010203, 8'h55, 0);
    send(8'h77);
    send(TERM);
    idle(2);
    check_held("bad_term");
    send_frame(24'h00D336, TERM, 0);

    // Timeout mid-frame, then a byte landing exactly on the expiry cycle.
    send(8'h00);
    send(8'hD3);
    idle(T + 3);
    check_held("timeout");
    send(8'h00);
    send(8'hD3);
    idle(T);
    send(8'h36);
    send(TERM);
    idle(2);
    check_held("byte_on_expiry");

    // Break mid-frame, dropped bytes, and break coinciding with a byte.
    send(8'h01);
    send(8'h02);
    step(1'b0, 8'h00, 1'b1);
    send(8'h33);
    send(8'h44);
    send(TERM);
    send(8'h05);
    step(1'b1, TERM, 1'b1);
    send(8'h06);
    send(TERM);
    step(1'b1, 8'h12, 1'b1);
    send(TERM);
    send_frame(24'h00D336, TERM, 0);
    idle(2);
    check_held("break");

    // Randomised traffic.
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      p    = ($urandom_range(0, 1) == 1) ? 24'($urandom_range(0, 100_000)) : 24'($urandom);
      case (kind)
        0, 1, 2, 3, 4, 5: send_frame(p, TERM, 3);
        6: begin
          send_frame(p, 8'($urandom_range(11, 255)), 2);
          for (int j = 0; j < int'($urandom_range(0, 3)); j++) send(8'($urandom));
          send(TERM);
        end
        7: begin
          cut = $urandom_range(0, 3);
          for (int unsigned j = 0; j < cut; j++) send(8'($urandom));
          step($urandom_range(0, 1) == 1, 8'($urandom), 1'b1);
          for (int j = 0; j < int'($urandom_range(0, 3)); j++) send(8'($urandom));
          send(TERM);
        end
        8: begin
          cut = $urandom_range(1, 3);
          for (int unsigned j = 0; j < cut; j++) send(8'($urandom));
          idle(T + $urandom_range(0, 5));
        end
        default: begin
          send(p[23:16]);
          idle(T - $urandom_range(0, 1));
          send(p[15:8]);
          send(p[7:0]);
          idle(T);
          send(TERM);
        end
      endcase
    end
    idle(3);
    check_held("random");

    // Reset after two bytes: partial frame dropped, no error pulse.
    send(8'h12);
    send(8'h34);
    resetn = 1'b0;
    model_reset();
    #2;
    check_reset_values("async_reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(T + 5);
    check_reset_values("after_reset");

    // 256 accepted frames wrap the counter back to zero.
    for (int n = 0; n < 256; n++) send_frame(24'($urandom), TERM, 0);
    idle(2);
    chk("count_wrap", 32'(frame_count), 32'd0);
    check_held("wrap");

    idle(5);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
